// File: rtl/rf_access_ctrl.sv
// Purpose: command front end for the 8x8 flip-flop register array; tracks written entries.
// Latency: accept edge -> ISSUE -> CAPTURE -> RESP (rsp_valid in 3rd cycle); 4 cycles min per command.
// Backpressure: cmd_ready only in IDLE; RESP stalls with stable outputs until rsp_ready.
module rf_access_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_status,
  output logic              rf_wr,
  output logic              rf_rd,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_din,
  input  logic [DATA_W-1:0] rf_dout,
  input  logic              rf_error,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_UNWR  = 2'b01;
  localparam logic [1:0] ST_RFERR = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t              state;
  logic                lat_write;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DEPTH-1:0]    wr_mask;

  // Ready is forced low while reset is asserted so nothing is taken during reset.
  assign cmd_ready = (state == IDLE) && resetn;
  assign busy      = (state != IDLE);

  // Command sequencer: strobes and response are registered so they are glitch-free.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      wr_mask    <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_status <= ST_OK;
      rf_wr      <= 1'b0;
      rf_rd      <= 1'b0;
      rf_addr    <= '0;
      rf_din     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            lat_write <= cmd_write;
            lat_addr  <= cmd_addr;
            lat_wdata <= cmd_wdata;
            // Exactly one strobe is raised for the single ISSUE cycle.
            rf_wr     <= cmd_write;
            rf_rd     <= !cmd_write;
            rf_addr   <= cmd_addr;
            rf_din    <= cmd_wdata;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // The array acts on this edge; mark the entry as holding real data.
          rf_wr <= 1'b0;
          rf_rd <= 1'b0;
          if (lat_write) begin
            wr_mask[lat_addr] <= 1'b1;
          end
          state <= CAPTURE;
        end
        CAPTURE: begin
          // Array outputs are registered, so they are valid during this cycle.
          if (lat_write) begin
            rsp_data <= lat_wdata;
          end else if (wr_mask[lat_addr]) begin
            rsp_data <= rf_dout;
          end else begin
            rsp_data <= '0;
          end
          // An array error outranks the unwritten indication.
          if (rf_error) begin
            rsp_status <= ST_RFERR;
          end else if (!lat_write && !wr_mask[lat_addr]) begin
            rsp_status <= ST_UNWR;
          end else begin
            rsp_status <= ST_OK;
          end
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed bench for rf_access_ctrl with a behavioural model of the register array.
// Expected responses come from a reference mask/memory and are queued at command issue.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_rf_access_ctrl;

  logic       clk;
  logic       resetn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_status;
  logic       rf_wr;
  logic       rf_rd;
  logic [2:0] rf_addr;
  logic [7:0] rf_din;
  logic [7:0] rf_dout;
  logic       rf_error;
  logic       busy;

  typedef struct {
    logic [7:0] data;
    logic [1:0] status;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ref_mem [8];
  logic [7:0] ref_mask;
  logic [7:0] arr_mem [8];
  int         compared;
  int         mismatched;
  int         cyc;
  int         a0, a1, a2;

  rf_access_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .rf_wr(rf_wr), .rf_rd(rf_rd), .rf_addr(rf_addr), .rf_din(rf_din),
    .rf_dout(rf_dout), .rf_error(rf_error), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Register array model: synchronous reset, registered read data.
  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) arr_mem[i] <= 8'h00;
      rf_dout <= 8'h00;
    end else if (rf_wr) begin
      arr_mem[rf_addr] <= rf_din;
    end else if (rf_rd) begin
      rf_dout <= arr_mem[rf_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The two array strobes must never coincide.
  always @(negedge clk) begin
    if (resetn === 1'b1) chk("strobe_overlap", {31'd0, rf_wr & rf_rd}, 32'd0);
  end

  function automatic exp_t model(input bit wr, input logic [2:0] addr, input logic [7:0] wd,
                                 input bit err);
    exp_t e;
    if (wr) begin
      e.data      = wd;
      e.status    = err ? 2'b10 : 2'b00;
      ref_mem[addr]  = wd;
      ref_mask[addr] = 1'b1;
    end else begin
      e.data   = ref_mask[addr] ? ref_mem[addr] : 8'h00;
      e.status = err ? 2'b10 : (ref_mask[addr] ? 2'b00 : 2'b01);
    end
    return e;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_data"}, {24'd0, rsp_data}, 32'd0);
    chk({tag, "_rsp_status"}, {30'd0, rsp_status}, 32'd0);
    chk({tag, "_rf_wr"}, {31'd0, rf_wr}, 32'd0);
    chk({tag, "_rf_rd"}, {31'd0, rf_rd}, 32'd0);
    chk({tag, "_rf_addr"}, {29'd0, rf_addr}, 32'd0);
    chk({tag, "_rf_din"}, {24'd0, rf_din}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // One complete command; entered and left on a falling edge.
  task automatic run_cmd(input bit wr, input logic [2:0] addr, input logic [7:0] wd,
                         input int stall, input logic [2:0] pend_addr, input bit err_inj,
                         input bit rst_cap, output int acc_cyc);
    exp_t e;
    exp_t got;
    int n;
    logic [7:0] d0;
    logic [1:0] s0;
    acc_cyc   = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    e = model(wr, addr, wd, err_inj);
    if (!rst_cap) sb.push_back(e);
    // ISSUE cycle
    @(negedge clk);
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    chk("issue_rf_wr", {31'd0, rf_wr}, {31'd0, wr});
    chk("issue_rf_rd", {31'd0, rf_rd}, {31'd0, !wr});
    chk("issue_rf_addr", {29'd0, rf_addr}, {29'd0, addr});
    if (wr) chk("issue_rf_din", {24'd0, rf_din}, {24'd0, wd});
    chk("issue_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("issue_busy", {31'd0, busy}, 32'd1);
    // CAPTURE cycle
    @(negedge clk);
    chk("capture_rf_wr", {31'd0, rf_wr}, 32'd0);
    chk("capture_rf_rd", {31'd0, rf_rd}, 32'd0);
    chk("capture_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rf_error  = err_inj;
    rsp_ready = (stall == 0);
    if (rst_cap) begin
      #1 resetn = 1'b0;
      #1 chk_reset_outputs("async_rst");
      ref_mask = 8'h00;
      for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
      rf_error  = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_held_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      resetn = 1'b1;
      return;
    end
    // First RESP cycle
    @(negedge clk);
    rf_error = 1'b0;
    chk("rsp_latency", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_rf_rd", {31'd0, rf_rd}, 32'd0);
    d0 = rsp_data;
    s0 = rsp_status;
    if (stall > 0) begin
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = pend_addr;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_rsp_data", {24'd0, rsp_data}, {24'd0, d0});
      chk("stall_rsp_status", {30'd0, rsp_status}, {30'd0, s0});
      chk("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    chk("sb_nonempty", sb.size(), 32'd1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk("rsp_data", {24'd0, rsp_data}, {24'd0, got.data});
      chk("rsp_status", {30'd0, rsp_status}, {30'd0, got.status});
    end
    // Handshake edge, back in IDLE
    @(negedge clk);
    chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    resetn     = 1'b0;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = 3'd0;
    cmd_wdata  = 8'h00;
    rsp_ready  = 1'b1;
    rf_error   = 1'b0;
    ref_mask   = 8'h00;
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Read of an unwritten entry
    run_cmd(1'b0, 3'd5, 8'h00, 0, 3'd0, 1'b0, 1'b0, a0);

    // Write then read same address, back to back
    run_cmd(1'b1, 3'd2, 8'hA5, 0, 3'd0, 1'b0, 1'b0, a0);
    run_cmd(1'b0, 3'd2, 8'h00, 0, 3'd0, 1'b0, 1'b0, a1);
    chk("b2b_spacing", a1 - a0, 32'd4);

    // Fill the array, then read back in reverse order
    for (int i = 0; i < 8; i++)
      run_cmd(1'b1, 3'(i), 8'(8'h11 * (i + 1)), 0, 3'd0, 1'b0, 1'b0, a0);
    for (int i = 7; i >= 0; i--)
      run_cmd(1'b0, 3'(i), 8'h00, 0, 3'd0, 1'b0, 1'b0, a0);

    // Response stall with a pending read, then array error on that read
    run_cmd(1'b0, 3'd6, 8'h00, 10, 3'd3, 1'b0, 1'b0, a1);
    run_cmd(1'b0, 3'd3, 8'h00, 0, 3'd0, 1'b1, 1'b0, a2);
    chk("pending_accept_spacing", a2 - a1, 32'd14);

    // Asynchronous reset during CAPTURE of a write
    run_cmd(1'b1, 3'd4, 8'h3C, 0, 3'd0, 1'b0, 1'b1, a0);
    chk("sb_drained", sb.size(), 32'd0);
    run_cmd(1'b0, 3'd4, 8'h00, 0, 3'd0, 1'b0, 1'b0, a0);
    run_cmd(1'b0, 3'd0, 8'h00, 0, 3'd0, 1'b0, 1'b0, a0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
